led_blink_driver: RTL and testbench
===================================

Name: led_blink_driver

Overview:
- Output-side counterpart to the debounced button input path: drives the 8 board LEDs for the Binary Number Game.
- In idle, shows a steady value (current guess or score).
- On a start request, flashes a latched pattern a given number of times with fixed on/off durations, then signals completion so game control can continue.
- Timing is counted in clk cycles at the 50 MHz board clock, using the same cycle-count style as the input settling time.

Parameters:
- LED_W, 8, LED bus width.
- ON_TICKS, 25000000, clk cycles the pattern is shown per blink (0.5 s); must be >= 1.
- OFF_TICKS, 25000000, clk cycles the LEDs are dark per blink (0.5 s); must be >= 1.
- CNT_W, 4, width of blink_count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- steady  in  LED_W  value displayed while idle
- start  in  1  single-cycle request; sampled only while busy=0
- pattern  in  LED_W  pattern to flash; latched on an accepted start
- blink_count  in  CNT_W  number of blinks; latched on an accepted start
- abort  in  1  cancel the current sequence
- busy  out  1  high while a sequence runs
- done  out  1  one-cycle pulse when a sequence completes normally
- led  out  LED_W  registered LED drive

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- While rst=1: led=0, busy=0, done=0, state=IDLE, all counters 0. This takes effect immediately, without a clock edge.
- States: IDLE, ON, OFF. A tick counter is sized $clog2(max(ON_TICKS,OFF_TICKS)+1). A remaining-blink counter is CNT_W bits.
- IDLE:
  - led <= steady each cycle (1-cycle latency).
  - start=1 with blink_count>0 at edge k: latch pattern and count. From cycle k+1: state=ON, led=pattern, busy=1, tick=0.
  - start=1 with blink_count=0: no blink. done=1 for the single cycle after edge k; busy stays 0; led keeps following steady.
- ON:
  - led=pattern_latched.
  - After ON_TICKS cycles in ON, move to OFF with led=0.
- OFF:
  - led=0.
  - After OFF_TICKS cycles, decrement the remaining count.
  - If the remaining count was 1: go to IDLE. busy=0, done=1 for exactly one cycle, led=steady in that same cycle.
  - Otherwise: go to ON.
- Total busy time for N>0 blinks is exactly N*(ON_TICKS+OFF_TICKS) cycles.
- start while busy=1 is ignored; the latched pattern and count do not change.
- start in the done cycle is accepted, since busy=0 in that cycle.
- abort=1 in ON or OFF:
  - Next cycle: IDLE, busy=0, led=steady.
  - done is not asserted.
  - abort has priority over a same-cycle phase transition.
- abort in IDLE has no effect; if start and abort are both high in IDLE, start is accepted.
- rst asserted mid-sequence: immediate reset values apply. After rst deasserts, the block stays in IDLE and no done is produced.
- Inputs steady, pattern, blink_count, start and abort are synchronous to clk. Upstream supplies them from debounced or registered sources; the block adds no synchronizers.
- blink_count=15 is the maximum; the counter never wraps because the decrement stops at 1→IDLE.

Decomposition:
- Shared game package holds:
  - state encoding constants IDLE/ON/OFF (2-bit localparams);
  - the CLK_HZ=50000000 constant;
  - the 0.5 s default tick value shared with other timing blocks.
- One natural sub-module: phase_timer. It is a loadable down-counter with a terminal-count pulse, reusable by any fixed-duration display phase.
- The top level holds the FSM, the latches and the led mux.

Test Plan (ON_TICKS=3, OFF_TICKS=2, LED_W=8):
- Reset: rst=1 with steady=8'h3C, no clock edge → led=00, busy=0, done=0. Release rst → led=3C on the next edge.
- start=1 with pattern=A5, blink_count=2 at edge k, steady=3C →
  - led = A5×3, 00×2, A5×3, 00×2 over cycles k+1..k+10;
  - busy=1 for exactly those 10 cycles;
  - at k+11: done=1 for 1 cycle, led=3C, busy=0.
- start with blink_count=0 → done=1 for the single cycle after start; busy never 1; led stays steady.
- start with pattern=FF mid-sequence → ignored, led still shows A5. A new start with pattern=0F, count=1 asserted in the done cycle → accepted; 0F×3, 00×2, then done.
- abort during the 2nd ON cycle of a 3-blink run → next cycle busy=0, led=steady; no done pulse within the next 20 cycles.
- Async rst pulsed mid-OFF between clock edges → led/busy/done go to 0 before the next edge. After release: IDLE, no done, led=steady on the following edge.

Source files
------------

// File: rtl/led_blink_driver_pkg.sv
// Shared game constants: state encoding for the LED blink FSM and the
// board-clock based timing defaults used by the display timing blocks.
package led_blink_driver_pkg;

    // Board clock frequency in Hz
    localparam int CLK_HZ = 50000000;

    // Default 0.5 s phase length, expressed in clk cycles
    localparam int HALF_SEC_TICKS = CLK_HZ / 2;

    // 2-bit state encodings for the blink sequencer
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_OFF  = ST_OFF
    } blink_state_e;

    // Larger of two phase lengths, used to size the shared tick counter
    function automatic int max_ticks(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_blink_driver_phase_timer.sv
// Loadable down-counter with a terminal-count flag. A phase of N cycles is
// timed by loading N-1 on entry; tc_o is high during the last cycle of the
// phase, so the owner can switch phase on that same edge.
module led_blink_driver_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/led_blink_driver.sv
// LED output driver for the Binary Number Game. Shows a steady value while
// idle; on request flashes a latched pattern a given number of times with
// fixed on/off phase lengths, then pulses done for one cycle.
module led_blink_driver
    import led_blink_driver_pkg::*;
#(
    parameter int LED_W     = 8,
    parameter int ON_TICKS  = HALF_SEC_TICKS,
    parameter int OFF_TICKS = HALF_SEC_TICKS,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] steady,
    input  logic             start,
    input  logic [LED_W-1:0] pattern,
    input  logic [CNT_W-1:0] blink_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [LED_W-1:0] led
);

    localparam int TICK_W = $clog2(max_ticks(ON_TICKS, OFF_TICKS) + 1);
    localparam logic [TICK_W-1:0] ON_LOAD  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LOAD = TICK_W'(OFF_TICKS - 1);

    blink_state_e     state_q,   state_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] remain_q,  remain_d;
    logic [LED_W-1:0] led_q,     led_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic              tmr_load;
    logic [TICK_W-1:0] tmr_val;
    logic              tmr_tc;

    led_blink_driver_phase_timer #(
        .W (TICK_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Next-state, latch and registered-output logic for the blink sequence
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        remain_d  = remain_q;
        led_d     = steady;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = ON_LOAD;

        case (state_q)
            S_IDLE: begin
                // abort is meaningless here, so start always wins
                if (start) begin
                    if (blink_count != '0) begin
                        state_d   = S_ON;
                        pattern_d = pattern;
                        remain_d  = blink_count;
                        led_d     = pattern;
                        busy_d    = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = ON_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_ON: begin
                led_d  = pattern_q;
                busy_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    led_d   = steady;
                    busy_d  = 1'b0;
                end else if (tmr_tc) begin
                    state_d  = S_OFF;
                    led_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end

            S_OFF: begin
                led_d  = '0;
                busy_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    led_d   = steady;
                    busy_d  = 1'b0;
                end else if (tmr_tc) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        // Last blink finished: hand control back
                        state_d = S_IDLE;
                        led_d   = steady;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_ON;
                        led_d    = pattern_q;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latches and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            remain_q  <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            remain_q  <= remain_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Self-checking bench for led_blink_driver with short phases
// (ON_TICKS=3, OFF_TICKS=2).
module tb_led_blink_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] steady = 8'h3C;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] blink_count = 4'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       start;
        logic [7:0] pattern;
        logic [3:0] count;
        logic       abort;
        logic [7:0] steady;
        logic [7:0] exp_led;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    led_blink_driver #(
        .LED_W     (8),
        .ON_TICKS  (3),
        .OFF_TICKS (2),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .steady      (steady),
        .start       (start),
        .pattern     (pattern),
        .blink_count (blink_count),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_led, input logic e_busy, input logic e_done);
        check({tag, ".led"},  led,          e_led);
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
        check({tag, ".done"}, {7'd0, done}, {7'd0, e_done});
        $display("%0t %s led=%h busy=%0d done=%0d", $time, tag, led, busy, done);
    endtask

    task automatic add(input logic s, input logic [7:0] p, input logic [3:0] c, input logic a,
                       input logic [7:0] st, input logic [7:0] el, input logic eb, input logic ed);
        vec_t v;
        v.start = s; v.pattern = p; v.count = c; v.abort = a; v.steady = st;
        v.exp_led = el; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        abort = 1'b0;
        pattern = 8'h00;
        blink_count = 4'd0;
    endtask

    initial begin
        // Table: inputs applied before an edge, outputs expected just after it
        add(1, 8'hA5, 4'd2, 0, 8'h3C, 8'hA5, 1, 0); // accepted start, ON1
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'hA5, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'hA5, 1, 0);
        add(1, 8'hFF, 4'd5, 0, 8'h3C, 8'h00, 1, 0); // start while busy ignored
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h00, 1, 0);
        add(1, 8'hFF, 4'd1, 0, 8'h3C, 8'hA5, 1, 0); // ignored again
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'hA5, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'hA5, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h3C, 0, 1); // done cycle
        add(1, 8'h0F, 4'd1, 0, 8'h3C, 8'h0F, 1, 0); // start in done cycle
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h0F, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h0F, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'h3C, 8'h3C, 0, 1);
        add(0, 8'h00, 4'd0, 0, 8'h5A, 8'h5A, 0, 0); // led follows steady
        add(1, 8'h77, 4'd0, 0, 8'h5A, 8'h5A, 0, 1); // zero-count start
        add(0, 8'h00, 4'd0, 0, 8'h5A, 8'h5A, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'hC3, 0, 0);
        add(1, 8'h81, 4'd1, 1, 8'hC3, 8'h81, 1, 0); // start+abort in IDLE
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'h81, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'h81, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'h00, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'hC3, 8'hC3, 0, 1);

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1 check_outs("reset_async", 8'h00, 1'b0, 1'b0);
        step();
        step();
        #2 rst = 1'b0;
        step();
        check_outs("reset_release", 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            pattern = vecs[i].pattern;
            blink_count = vecs[i].count;
            abort = vecs[i].abort;
            steady = vecs[i].steady;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Abort during the 2nd ON cycle of a 3-blink run
        idle_inputs();
        steady = 8'h3C;
        step();
        start = 1'b1; pattern = 8'h99; blink_count = 4'd3;
        step();
        idle_inputs();
        check_outs("abort_on1", 8'h99, 1'b1, 1'b0);
        step();
        check_outs("abort_on2", 8'h99, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort_idle", 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_outs($sformatf("abort_quiet%0d", i), 8'h3C, 1'b0, 1'b0);
        end

        // Abort in the last ON cycle beats the ON->OFF transition
        start = 1'b1; pattern = 8'h99; blink_count = 4'd2;
        step();
        idle_inputs();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort_prio", 8'h3C, 1'b0, 1'b0);

        // Asynchronous reset mid-OFF, between edges
        step();
        start = 1'b1; pattern = 8'h66; blink_count = 4'd2;
        step();
        idle_inputs();
        step();
        step();
        step();
        check_outs("rst_off1", 8'h00, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("rst_mid", 8'h00, 1'b0, 1'b0);
        step();
        #2 rst = 1'b0;
        step();
        check_outs("rst_after", 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_outs($sformatf("rst_quiet%0d", i), 8'h3C, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
